// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encodings and frame constants.
// Both the transmitter and the receiver import this package.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_START     = 3'b001,
    ST_DATA      = 3'b010,
    ST_PARITY    = 3'b011,
    ST_STOP      = 3'b100,
    ST_LOAD      = 3'b101,
    ST_WAIT_IDLE = 3'b110
  } state_t;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Receiver-side bundle: serial line in, received byte and status out,
// and the valid/ack handshake. master = receiver, slave = consumer.
interface uart_rx_fsm_if;
  import uart_pkg::*;

  logic                 rx;
  logic                 data_ack;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 parity_error;
  logic                 framing_error;
  logic                 overrun;
  logic                 busy;
  logic [2:0]           state;

  modport master (
    input  rx,
    input  data_ack,
    output data_out,
    output data_valid,
    output parity_error,
    output framing_error,
    output overrun,
    output busy,
    output state
  );

  modport slave (
    output rx,
    output data_ack,
    input  data_out,
    input  data_valid,
    input  parity_error,
    input  framing_error,
    input  overrun,
    input  busy,
    input  state
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus a falling-edge
// detector on the synchronised value. All flops reset to the idle level (1)
// so that reset release never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronise rx and keep one cycle of history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rx;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rx_s = sync;
  assign fall = prev & ~sync;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: 1 start bit, 8 data bits LSB first, optional even parity,
// 1 stop bit. Bits are sampled at mid-bit using a baud counter; the byte is
// presented on a level valid/ack handshake with parity, framing and overrun
// status. CLKS_PER_BIT must be at least 4.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fsm_if.master bus
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 fall;

  state_t               state_q;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_acc;
  logic                 perr;
  logic                 ferr;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 ovr_q;
  logic                 busy_q;

  logic                 bit_sample;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (bus.rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  assign bit_sample = (baud_cnt == BAUD_LAST);

  // Receive FSM with inline baud/bit counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_acc  <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // An ack only counts while a byte is pending; LOAD below overrides it.
      if (bus.data_ack && valid_q) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_q  <= ST_START;
            baud_cnt <= '0;
            busy_q   <= 1'b1;
          end
        end

        ST_START: begin
          if (baud_cnt == HALF_LAST) begin
            if (rx_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= ST_DATA;
              baud_cnt <= '0;
              bit_cnt  <= '0;
              par_acc  <= 1'b0;
              perr     <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_sample) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[DATA_BITS-1:1]};
            par_acc  <= par_acc ^ rx_s;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == BIT_LAST) begin
              state_q <= PARITY_EN ? ST_PARITY : ST_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_PARITY: begin
          if (bit_sample) begin
            baud_cnt <= '0;
            perr     <= par_acc ^ rx_s;
            state_q  <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (bit_sample) begin
            baud_cnt <= '0;
            ferr     <= ~rx_s;
            state_q  <= ST_LOAD;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_LOAD: begin
          data_q  <= shift;
          perr_q  <= perr;
          ferr_q  <= ferr;
          valid_q <= 1'b1;
          if (valid_q && !bus.data_ack) begin
            ovr_q <= 1'b1;
          end
          state_q <= ferr ? ST_WAIT_IDLE : ST_IDLE;
          busy_q  <= ferr;
        end

        ST_WAIT_IDLE: begin
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out      = data_q;
  assign bus.data_valid    = valid_q;
  assign bus.parity_error  = perr_q;
  assign bus.framing_error = ferr_q;
  assign bus.overrun       = ovr_q;
  assign bus.busy          = busy_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: one instance with even parity and one
// without, both at 16 clocks per bit, sharing the same rx line and reset.
`timescale 1ns/1ns
module tb_uart_rx_fsm;
  import uart_pkg::*;

  localparam int CPB    = 16;
  localparam int HALF   = CPB / 2;
  localparam int PERIOD = 10;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic rx_line = 1'b1;

  int  n_compared   = 0;
  int  n_mismatched = 0;
  time t_start      = 0;
  time rise_p       = 0;
  time rise_np      = 0;

  uart_rx_fsm_if bus_p ();
  uart_rx_fsm_if bus_np ();

  assign bus_p.rx  = rx_line;
  assign bus_np.rx = rx_line;

  uart_rx_fsm #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut_p (
    .clk (clk),
    .rst (rst),
    .bus (bus_p.master)
  );

  uart_rx_fsm #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut_np (
    .clk (clk),
    .rst (rst),
    .bus (bus_np.master)
  );

  // Free-running clock
  always #(PERIOD / 2) clk = ~clk;

  // Timestamp each rise of data_valid to measure latency from the start edge
  always @(posedge bus_p.data_valid) rise_p = $time;
  always @(posedge bus_np.data_valid) rise_np = $time;

  // Convert a posedge timestamp into the posedge index counted from t_start
  function automatic int edges_since_start(input time t);
    return int'((t - t_start + PERIOD / 2) / PERIOD);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Drives a whole frame; the line is left at the stop-bit level afterwards
  task automatic send_frame(input logic [7:0] d, input bit with_parity,
                            input logic par, input logic stop);
    t_start = $time;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (with_parity) send_bit(par);
    send_bit(stop);
  endtask

  task automatic ack_p();
    bus_p.data_ack = 1'b1;
    @(negedge clk);
    bus_p.data_ack = 1'b0;
  endtask

  initial begin
    bus_p.data_ack  = 1'b0;
    bus_np.data_ack = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    check_output("rst_state",  32'(bus_p.state), 32'(ST_IDLE));
    check_output("rst_valid",  32'(bus_p.data_valid), 32'd0);
    check_output("rst_data",   32'(bus_p.data_out), 32'h00);
    check_output("rst_busy",   32'(bus_p.busy), 32'd0);
    check_output("rst_ovr",    32'(bus_p.overrun), 32'd0);
    check_output("rst_perr",   32'(bus_p.parity_error), 32'd0);
    check_output("rst_ferr",   32'(bus_p.framing_error), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5 has four ones, so the even parity bit is 0.
    // Stop bit (index 10) is sampled on edge 3+HALF+10*CPB = 171; valid on 172.
    $display("[TB] case 1: 0xA5 good frame");
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    check_output("c1_data",  32'(bus_p.data_out), 32'hA5);
    check_output("c1_perr",  32'(bus_p.parity_error), 32'd0);
    check_output("c1_ferr",  32'(bus_p.framing_error), 32'd0);
    check_output("c1_valid", 32'(bus_p.data_valid), 32'd1);
    check_output("c1_rise",  32'(edges_since_start(rise_p)), 32'(3 + HALF + 10 * CPB + 1));
    check_output("c1_state", 32'(bus_p.state), 32'(ST_IDLE));
    check_output("c1_busy",  32'(bus_p.busy), 32'd0);
    ack_p();
    check_output("c1_ack",   32'(bus_p.data_valid), 32'd0);

    $display("[TB] case 2: parity error then framing error");
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    check_output("c2_data",  32'(bus_p.data_out), 32'h3C);
    check_output("c2_perr",  32'(bus_p.parity_error), 32'd1);
    check_output("c2_ferr",  32'(bus_p.framing_error), 32'd0);
    ack_p();
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check_output("c2b_data",  32'(bus_p.data_out), 32'h00);
    check_output("c2b_perr",  32'(bus_p.parity_error), 32'd0);
    check_output("c2b_ferr",  32'(bus_p.framing_error), 32'd1);
    check_output("c2b_valid", 32'(bus_p.data_valid), 32'd1);
    check_output("c2b_state", 32'(bus_p.state), 32'(ST_WAIT_IDLE));
    check_output("c2b_busy",  32'(bus_p.busy), 32'd1);
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    check_output("c2b_idle",  32'(bus_p.state), 32'(ST_IDLE));
    ack_p();

    // Low for 5 clk: START entered on edge 3, line back high by edge 7,
    // start sample on edge 3+HALF = 11 sees 1 and rejects.
    $display("[TB] case 3: glitch rejection");
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    check_output("c3_start", 32'(bus_p.state), 32'(ST_START));
    check_output("c3_busy",  32'(bus_p.busy), 32'd1);
    @(negedge clk);
    rx_line = 1'b1;
    repeat (7) @(negedge clk);
    check_output("c3_idle",  32'(bus_p.state), 32'(ST_IDLE));
    check_output("c3_nbusy", 32'(bus_p.busy), 32'd0);
    check_output("c3_valid", 32'(bus_p.data_valid), 32'd0);

    $display("[TB] case 4: back-to-back frames with overrun");
    send_frame(8'h11, 1'b1, 1'b0, 1'b1);
    check_output("c4_first", 32'(bus_p.overrun), 32'd0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1);
    check_output("c4_data",  32'(bus_p.data_out), 32'h22);
    check_output("c4_ovr",   32'(bus_p.overrun), 32'd1);
    check_output("c4_valid", 32'(bus_p.data_valid), 32'd1);
    ack_p();
    check_output("c4_ack_v", 32'(bus_p.data_valid), 32'd0);
    check_output("c4_ack_o", 32'(bus_p.overrun), 32'd0);

    $display("[TB] case 5: reset mid-frame");
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check_output("c5_data_st", 32'(bus_p.state), 32'(ST_DATA));
    check_output("c5_busy",    32'(bus_p.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_output("c5_rst_st",  32'(bus_p.state), 32'(ST_IDLE));
    check_output("c5_rst_bsy", 32'(bus_p.busy), 32'd0);
    check_output("c5_rst_v",   32'(bus_p.data_valid), 32'd0);
    check_output("c5_rst_d",   32'(bus_p.data_out), 32'h00);
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    check_output("c5_data",  32'(bus_p.data_out), 32'h5A);
    check_output("c5_perr",  32'(bus_p.parity_error), 32'd0);
    check_output("c5_ferr",  32'(bus_p.framing_error), 32'd0);
    check_output("c5_valid", 32'(bus_p.data_valid), 32'd1);
    ack_p();

    // No parity: stop bit is index 9, sampled on edge 3+HALF+9*CPB = 155.
    $display("[TB] case 6: no-parity instance, 0x81");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    check_output("c6_data",  32'(bus_np.data_out), 32'h81);
    check_output("c6_perr",  32'(bus_np.parity_error), 32'd0);
    check_output("c6_ferr",  32'(bus_np.framing_error), 32'd0);
    check_output("c6_valid", 32'(bus_np.data_valid), 32'd1);
    check_output("c6_rise",  32'(edges_since_start(rise_np)), 32'(3 + HALF + 9 * CPB + 1));
    check_output("c6_ovr",   32'(bus_np.overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
